// File: rtl/piano_voice_tracker.sv
// PS/2 scan-code decoder that tracks up to NUM_CH held piano keys and drives
// one octave-shifted half-period count per voice channel.
module piano_voice_tracker #(
  parameter int NUM_CH   = 2,
  parameter int PERIOD_W = 18,
  parameter int OCT_MAX  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 scan_code,
  input  logic                       scan_valid,
  output logic [NUM_CH*PERIOD_W-1:0] half_period,
  output logic [NUM_CH-1:0]          ch_active,
  output logic [1:0]                 octave
);

  localparam logic [1:0] OCT_TOP = 2'(OCT_MAX);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t state, state_nxt;
  logic   make_ev, brk_ev;

  logic [NUM_CH-1:0]       ch_vld_p0, vld_nxt;
  logic [NUM_CH-1:0][2:0]  ch_idx_p0, idx_nxt;
  logic [1:0]              oct_p0, oct_nxt;

  logic [NUM_CH-1:0]       hit, free_oh;
  logic                    any_hit, free_found, key_mapped;
  logic [2:0]              key_idx;

  // Returns {mapped, key index} for a make/break code.
  function automatic logic [3:0] key_lookup(input logic [7:0] code);
    case (code)
      8'h1C:   return 4'b1_000;
      8'h1D:   return 4'b1_001;
      8'h1B:   return 4'b1_010;
      8'h23:   return 4'b1_011;
      8'h24:   return 4'b1_100;
      8'h2B:   return 4'b1_101;
      8'h2D:   return 4'b1_110;
      8'h2C:   return 4'b1_111;
      default: return 4'b0_000;
    endcase
  endfunction

  function automatic logic [17:0] base_period(input logic [2:0] idx);
    case (idx)
      3'd0:    return 18'd227273;
      3'd1:    return 18'd214592;
      3'd2:    return 18'd202429;
      3'd3:    return 18'd190840;
      3'd4:    return 18'd180505;
      3'd5:    return 18'd170068;
      3'd6:    return 18'd160722;
      default: return 18'd151515;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    make_ev   = 1'b0;
    brk_ev    = 1'b0;
    if (scan_valid) begin
      case (state)
        IDLE: begin
          if (scan_code == 8'hF0)      state_nxt = BRK;
          else if (scan_code == 8'hE0) state_nxt = EXT;
          else                         make_ev   = 1'b1;
        end
        BRK: begin
          if (scan_code == 8'hF0)      state_nxt = BRK;
          else if (scan_code == 8'hE0) state_nxt = EXT;
          else begin
            brk_ev    = 1'b1;
            state_nxt = IDLE;
          end
        end
        EXT: begin
          if (scan_code == 8'hF0) state_nxt = EXT_BRK;
          else                    state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    {key_mapped, key_idx} = key_lookup(scan_code);
    hit        = '0;
    free_oh    = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = ch_vld_p0[i] && (ch_idx_p0[i] == key_idx);
      if (!ch_vld_p0[i] && !free_found) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
    any_hit = |hit;

    vld_nxt = ch_vld_p0;
    idx_nxt = ch_idx_p0;
    oct_nxt = oct_p0;
    // A key can live in at most one channel, so a break clears a single bit.
    if (brk_ev && key_mapped) vld_nxt = ch_vld_p0 & ~hit;
    if (make_ev && key_mapped && !any_hit) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (free_oh[i]) begin
          vld_nxt[i] = 1'b1;
          idx_nxt[i] = key_idx;
        end
      end
    end
    if (make_ev && scan_code == 8'h1A && oct_p0 != 2'd0)   oct_nxt = oct_p0 - 2'd1;
    if (make_ev && scan_code == 8'h22 && oct_p0 < OCT_TOP) oct_nxt = oct_p0 + 2'd1;
  end

  // Stage 0: channel table and octave register update on the sampling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_vld_p0 <= '0;
      ch_idx_p0 <= '0;
      oct_p0    <= '0;
    end else begin
      ch_vld_p0 <= vld_nxt;
      ch_idx_p0 <= idx_nxt;
      oct_p0    <= oct_nxt;
    end
  end

  // Stage 1: registered per-channel tone outputs derived from the stage-0 state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_period <= '0;
      ch_active   <= '0;
      octave      <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        half_period[i*PERIOD_W +: PERIOD_W] <= ch_vld_p0[i] ?
          PERIOD_W'(base_period(ch_idx_p0[i]) >> oct_p0) : '0;
      end
      ch_active <= ch_vld_p0;
      octave    <= oct_p0;
    end
  end

endmodule

// File: doc/piano_voice_tracker.md
# piano_voice_tracker

Parametrised successor to the single-key note decoder. It consumes PS/2 scan-code bytes and decodes make and break sequences, including the 0xF0 and 0xE0 prefixes. It tracks up to NUM_CH simultaneously held piano keys and applies a user-selected octave shift. Per channel it outputs a registered half-period count and an active flag. It sits between the PS/2 byte receiver and the per-channel tone generators.

## Interface
- NUM_CH, 2: number of voice channels (1..8).
- PERIOD_W, 18: width of each half-period count; must be ≥18.
- OCT_MAX, 2: highest octave shift (0..3).

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- scan_code  in  8  received PS/2 byte.
- scan_valid  in  1  one-cycle strobe; scan_code is valid while high.
- half_period  out  NUM_CH*PERIOD_W  channel i occupies bits [i*PERIOD_W +: PERIOD_W]; 0 when idle.
- ch_active  out  NUM_CH  bit i high while channel i holds a key.
- octave  out  2  current octave shift.

## Operation
- Key table (make code -> base half-period, octave 0):
  - 0x1C a=227273
  - 0x1D w=214592
  - 0x1B s=202429
  - 0x23 d=190840
  - 0x24 e=180505
  - 0x2B f=170068
  - 0x2D r=160722
  - 0x2C t=151515
- Codes outside the table map to "unmapped".
- Octave keys: 0x1A (z) decrements the octave and 0x22 (x) increments it. Both saturate at 0 and OCT_MAX. They act on make only; their break is ignored.
- Prefix FSM, advanced only on scan_valid:
  - IDLE: 0xF0->BRK; 0xE0->EXT; any other byte is a make event, stay IDLE.
  - BRK: 0xF0 stays BRK; 0xE0->EXT; any other byte is a break event, ->IDLE.
  - EXT: 0xF0->EXT_BRK; any other byte is discarded, ->IDLE.
  - EXT_BRK: any byte is discarded, ->IDLE.
- Make of a mapped key:
  - Key already held in some channel: no change. Typematic repeat is suppressed.
  - Otherwise: allocate the lowest-index free channel and store its key index (3 bits).
  - No free channel: the event is dropped. No stealing.
- Break of a mapped key: free the channel holding it. If no channel holds it, no change.
- Make or break of an unmapped, non-octave key: no change.
- Output per channel: half_period_i = active ? (base[idx] >> octave), zero-extended to PERIOD_W : 0. ch_active_i = channel valid.
- An octave change immediately retunes all held channels.
- Reset: FSM=IDLE, all channels free, octave=0, half_period=0, ch_active=0.
- reset asserted mid-sequence drops any pending prefix and all held notes. The next byte after release is decoded from IDLE.

## Timing
- Byte sampled at edge k (scan_valid=1). At edge k, the FSM, channel table and octave register update.
- half_period, ch_active and octave are registered from that state at edge k+1.
- Latency is 2 edges from the sampling edge to the visible output.
- Outputs are recomputed every cycle. Outputs are stable between events.
- scan_valid may be asserted on consecutive cycles. Each byte is processed in order with no stall.
- Within one event the order is: FSM decode, then channel free/allocate. One byte never both frees and allocates.
- scan_valid=0: no state change.
- Reset asynchronous assertion: outputs go to 0 immediately. Release is synchronous to clk by the system.

## Test plan
- Reset, then send 0x1C -> 2 cycles later ch_active=01, ch0=227273, ch1=0. Send 0xF0,0x1C -> ch_active=00, ch0=0.
- Send 0x1C, 0x23, 0x2C (NUM_CH=2) -> ch0=227273, ch1=190840, t dropped. Send break 0x1C, then 0x2C -> ch0=151515, ch1 unchanged.
- Hold a, then send 0x22, 0x22, 0x22 -> octave 1: ch0=113636; octave 2: ch0=56818; third press saturates at 2. Send 0x1A x3 -> octave 0, ch0=227273.
- Send 0x1C three times (typematic repeat) -> only ch0 active. A single break frees it.
- Send 0xE0,0x1C and 0xE0,0xF0,0x1C -> no channel change, FSM back in IDLE. A following 0x1C allocates ch0.
- Hold two keys at octave 1, pulse reset between 0xF0 and 0x1C -> all outputs 0, octave 0. The following 0x1C is treated as a make and allocates ch0=227273.
